// File: rtl/ks_pkg.sv
// Shared helpers for the prefix-adder family:
// operand-width legality and pipeline depth.
package ks_pkg;

  localparam int KS_MIN_W = 4;
  localparam int KS_MAX_W = 64;

  function automatic bit ks_width_ok(input int w);
    return (w >= KS_MIN_W) && (w <= KS_MAX_W)
      && ((w & (w - 1)) == 0);
  endfunction

  // S0 + one register per prefix level + result stage
  function automatic int ks_stages(input int w);
    return $clog2(w) + 2;
  endfunction

endpackage

// File: rtl/ks_cell.sv
// Kogge-Stone prefix operator on one (hi, lo)
// pair of group generate/propagate terms.
module ks_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract unit with a
// valid/ready stream handshake and global stall.
module ks_adder_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sub,
  input  logic             i_c0,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int STAGES = ks_stages(WIDTH);

  if (!ks_width_ok(WIDTH)) begin : g_bad_width
    $error("ks_adder_pipe: illegal WIDTH");
  end
  if (STAGES != LEVELS + 2) begin : g_bad_depth
    $error("ks_adder_pipe: stage count mismatch");
  end

  logic adv;
  logic ovld_q;

  assign adv     = ~ovld_q | i_ready;
  assign o_ready = adv;
  assign o_valid = ovld_q;

  logic [WIDTH-1:0] bx_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic             cin_s;

  assign bx_s  = i_b ^ {WIDTH{i_sub}};
  assign cin_s = i_sub | i_c0;
  assign p_s   = i_a ^ bx_s;

  // Fold carry-in into bit 0 so the tree
  // resolves every carry including cout.
  always_comb begin
    g_s    = i_a & bx_s;
    g_s[0] = g_s[0] | (p_s[0] & cin_s);
  end

  logic [LEVELS:0]             v_q;
  logic [LEVELS:0]             c_q;
  logic [LEVELS:0][WIDTH-1:0]  g_q;
  logic [LEVELS:0][WIDTH-1:0]  p_q;
  logic [LEVELS:0][WIDTH-1:0]  x_q;
  logic [LEVELS:1][WIDTH-1:0]  g_d;
  logic [LEVELS:1][WIDTH-1:0]  p_d;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int SPAN = 1 << (k - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < SPAN) begin : g_pass
        assign g_d[k][i] = g_q[k-1][i];
        assign p_d[k][i] = p_q[k-1][i];
      end else begin : g_op
        ks_cell u_cell (
          .g_hi_i (g_q[k-1][i]),
          .p_hi_i (p_q[k-1][i]),
          .g_lo_i (g_q[k-1][i-SPAN]),
          .p_lo_i (p_q[k-1][i-SPAN]),
          .g_o    (g_d[k][i]),
          .p_o    (p_d[k][i])
        );
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (adv) begin
      g_q[0] <= g_s;
      p_q[0] <= p_s;
      x_q[0] <= p_s;
      c_q[0] <= cin_s;
      for (int k = 1; k <= LEVELS; k++) begin
        g_q[k] <= g_d[k];
        p_q[k] <= p_d[k];
        x_q[k] <= x_q[k-1];
        c_q[k] <= c_q[k-1];
      end
    end
  end

  logic [WIDTH-1:0] carry_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  assign carry_d = {g_q[LEVELS][WIDTH-2:0],
                    c_q[LEVELS]};
  assign sum_d   = x_q[LEVELS] ^ carry_d;
  assign cout_d  = g_q[LEVELS][WIDTH-1];
  assign ovf_d   = cout_d ^ g_q[LEVELS][WIDTH-2];

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v_q    <= '0;
      ovld_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv) begin
      v_q    <= {v_q[LEVELS-1:0], i_valid};
      ovld_q <= v_q[LEVELS];
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign o_sum  = sum_q;
  assign o_cout = cout_q;
  assign o_ovf  = ovf_q;

  // Group propagate of the last level has no consumer.
  logic unused_p;
  assign unused_p = ^p_q[LEVELS];

endmodule

// File: doc/ks_adder_pipe.md
KS_ADDER_PIPE -- requirements
Module: ks_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the operand width and be a power of two, 4 to 64 inclusive.
REQ-002 Parameter LEVELS, default $clog2(WIDTH), SHALL be derived and never overridden.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 i_valid  input  1  operand beat present.
REQ-006 o_ready  output  1  block accepts a beat this cycle.
REQ-007 i_sub  input  1  0 = A+B+i_c0; 1 = A-B (B inverted, carry-in forced 1, i_c0 ignored).
REQ-008 i_c0  input  1  carry-in for add mode.
REQ-009 i_a, i_b  input  WIDTH  operands.
REQ-010 o_valid  output  1  result beat present.
REQ-011 i_ready  input  1  downstream accepts the result.
REQ-012 o_sum  output  WIDTH  result.
REQ-013 o_cout  output  1  carry out of the MSB (1 = no borrow in subtract mode).
REQ-014 o_ovf  output  1  signed two's-complement overflow.

Function
REQ-015 Pipeline SHALL be LEVELS+2 register stages: S0 = bitwise p/g plus operand-B-adjusted carry-in; S1..S(LEVELS) = one Kogge-Stone prefix level each, span 2^(k-1) at level k; final stage = sum/cout/ovf.
REQ-016 Bit i SHALL compute p = a XOR b', g = a AND b', where b' = b XOR i_sub.
REQ-017 Carry-in SHALL enter as generate term g[-1] at S0 so the prefix tree yields every carry, including cout, without a ripple term.
REQ-018 Sum SHALL be p[i] XOR c[i]; cout SHALL be c[WIDTH]; ovf SHALL be c[WIDTH] XOR c[WIDTH-1].
REQ-019 Latency from an accepted beat (i_valid AND o_ready) to o_valid SHALL be exactly LEVELS+2 cycles with no stalls (6 for WIDTH=16).
REQ-020 Each stage SHALL carry a valid bit; all stages SHALL advance together when advance = NOT o_valid OR i_ready.
REQ-021 o_ready SHALL equal advance, combinationally; throughput SHALL be one beat per cycle while i_ready is held high.
REQ-022 When advance = 0, every stage's data and valid SHALL hold; o_sum/o_cout/o_ovf SHALL remain stable while o_valid=1 and i_ready=0.
REQ-023 Bubbles (i_valid=0 on an advancing cycle) SHALL propagate as valid=0; data registers of invalid stages MAY hold any value.
REQ-024 Beats SHALL exit in acceptance order, with none dropped or duplicated.
REQ-025 A beat presented while o_ready=0 SHALL NOT be captured; the upstream holds it.

Reset
REQ-026 On i_rst=1 all stage valid bits SHALL clear immediately (asynchronously); o_valid SHALL read 0 within the reset cycle.
REQ-027 o_sum, o_cout and o_ovf SHALL reset to 0; other data registers need no reset.
REQ-028 Reset mid-operation SHALL discard every in-flight beat; the first beat accepted after release SHALL appear after LEVELS+2 cycles.
REQ-029 o_ready SHALL be 1 during and immediately after reset.

Structure
REQ-030 Shared package ks_pkg SHALL hold the WIDTH legality check and the stage-count function (LEVELS+2), for reuse by other adder variants.
REQ-031 One sub-module, ks_cell, SHALL implement the prefix operator (G = g_hi OR (p_hi AND g_lo), P = p_hi AND p_lo); ks_adder_pipe SHALL instantiate it via generate loops over level and bit.
REQ-032 Bits below the span at a level SHALL pass through unchanged (buffer, no cell).

Verification (WIDTH=16)
REQ-033 a=0xFFFF, b=0x0001, c0=0, add -> 6 cycles later: sum=0x0000, cout=1, ovf=0.
REQ-034 a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1; a=0x0005, b=0x0007, sub -> sum=0xFFFE, cout=0, ovf=0.
REQ-035 Stream 8 random beats back-to-back, drop i_ready for 3 cycles at beat 3 -> o_ready low for exactly those cycles, outputs stable, all 8 results correct and in order.
REQ-036 Assert i_rst with 4 beats in flight -> o_valid=0 at once; no stale beat appears after release; next beat has 6-cycle latency.
REQ-037 10^5 random beats with random i_valid/i_ready/i_sub/i_c0 against a behavioural model, plus WIDTH=4 and WIDTH=64 builds -> zero mismatches.
